// File: rtl/common_fifo_shift_1w1r_lvl_pkg.sv
// Shared definitions for the common_fifo_* family: count-width helper,
// default level constants and the per-entry next-value select encoding.
package common_fifo_shift_1w1r_lvl_pkg;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Default almost-empty level; almost-full defaults to depth-1 at the use site.
  localparam int DEF_AE_LEVEL = 1;

  // Next-value source for one shifting entry.
  typedef enum logic [1:0] {
    ENTRY_HOLD  = 2'd0,
    ENTRY_SHIFT = 2'd1,
    ENTRY_LOAD  = 2'd2
  } entry_sel_e;

endpackage

// File: rtl/common_fifo_shift_entry.sv
// One storage slot of the shifting FIFO: holds, takes the neighbour above
// it (shift toward the head), or loads the write data.
module common_fifo_shift_entry
  import common_fifo_shift_1w1r_lvl_pkg::*;
#(
  parameter int                    FIFO_WIDTH       = 8,
  parameter logic [FIFO_WIDTH-1:0] FIFO_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  entry_sel_e            sel,
  input  logic [FIFO_WIDTH-1:0] shift_in,
  input  logic [FIFO_WIDTH-1:0] din,
  output logic [FIFO_WIDTH-1:0] entry
);

  logic [FIFO_WIDTH-1:0] entry_q;
  logic [FIFO_WIDTH-1:0] entry_d;

  // Three-way next-value select.
  always_comb begin
    entry_d = entry_q;
    case (sel)
      ENTRY_SHIFT: entry_d = shift_in;
      ENTRY_LOAD:  entry_d = din;
      default:     entry_d = entry_q;
    endcase
  end

  // Entry register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) entry_q <= FIFO_RESET_VALUE;
    else       entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/common_fifo_shift_1w1r_lvl.sv
// 1-write/1-read shifting FIFO with first-word-fall-through head, binary
// occupancy count, programmable almost-full/empty levels, synchronous flush
// and registered overflow/underflow pulses.
module common_fifo_shift_1w1r_lvl
  import common_fifo_shift_1w1r_lvl_pkg::*;
#(
  parameter int                    FIFO_DEPTH       = 4,
  parameter int                    FIFO_WIDTH       = 8,
  parameter int                    AF_LEVEL         = FIFO_DEPTH - 1,
  parameter int                    AE_LEVEL         = DEF_AE_LEVEL,
  parameter bit                    PUSH_ON_FULL_POP = 1'b1,
  parameter logic [FIFO_WIDTH-1:0] FIFO_RESET_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [FIFO_WIDTH-1:0]             din,
  input  logic                              wen,
  output logic [FIFO_WIDTH-1:0]             dout,
  input  logic                              ren,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic                              err_overflow,
  output logic                              err_underflow
);

  localparam int CW = fifo_count_width(FIFO_DEPTH);

  // Parameter legality, caught at elaboration.
  if (FIFO_DEPTH < 1) begin : g_chk_depth
    $error("FIFO_DEPTH must be at least 1");
  end
  if (FIFO_WIDTH < 1) begin : g_chk_width
    $error("FIFO_WIDTH must be at least 1");
  end
  if (AF_LEVEL > FIFO_DEPTH || AF_LEVEL < 0) begin : g_chk_af
    $error("AF_LEVEL must lie in 0..FIFO_DEPTH");
  end
  if (AE_LEVEL > FIFO_DEPTH || AE_LEVEL < 0) begin : g_chk_ae
    $error("AE_LEVEL must lie in 0..FIFO_DEPTH");
  end

  logic [CW-1:0]         count_q, count_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_underflow_q, err_underflow_d;
  logic [FIFO_WIDTH-1:0] entry_q   [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] shift_src [FIFO_DEPTH];
  entry_sel_e            entry_sel [FIFO_DEPTH];
  logic                  pop, push;

  // Status flags decode straight from the count register.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign dout       = entry_q[0];

  // A level of zero makes almost_full permanently true; spelled out to avoid
  // an always-true unsigned compare.
  if (AF_LEVEL == 0) begin : g_af_const
    assign almost_full = 1'b1;
  end else begin : g_af_cmp
    assign almost_full = (count_q >= CW'(AF_LEVEL));
  end
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

  // Accept decisions; pop may free the slot a full-FIFO push needs.
  assign pop  = ren & ~fifo_empty;
  assign push = wen & (~fifo_full | (PUSH_ON_FULL_POP & pop));

  // Per-entry select: shift below the tail on pop, write din at the new tail.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entry_sel[i] = ENTRY_HOLD;
      if (!flush) begin
        if (pop && (i < int'(count_q) - 1))
          entry_sel[i] = ENTRY_SHIFT;
        else if (push && pop && (i == int'(count_q) - 1))
          entry_sel[i] = ENTRY_LOAD;
        else if (push && !pop && (i == int'(count_q)))
          entry_sel[i] = ENTRY_LOAD;
      end
    end
  end

  // Next occupancy and error pulses; flush overrides everything.
  always_comb begin
    count_d         = count_q;
    err_overflow_d  = wen & ~push & ~flush;
    err_underflow_d = ren & fifo_empty & ~flush;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  // Count and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q         <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      count_q         <= count_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // Storage chain; the tail slot has no upper neighbour and never shifts.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    if (gi < FIFO_DEPTH - 1) begin : g_mid
      assign shift_src[gi] = entry_q[gi+1];
    end else begin : g_tail
      assign shift_src[gi] = entry_q[gi];
    end

    common_fifo_shift_entry #(
      .FIFO_WIDTH       (FIFO_WIDTH),
      .FIFO_RESET_VALUE (FIFO_RESET_VALUE)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .sel      (entry_sel[gi]),
      .shift_in (shift_src[gi]),
      .din      (din),
      .entry    (entry_q[gi])
    );
  end

endmodule

// File: tb/tb_common_fifo_shift_1w1r_lvl.sv
// Three FIFOs share one stimulus stream: depth 4 with push-on-full-pop,
// depth 4 without it, and depth 1 with it. A queue-based model predicts
// each one; the monitor compares predictions a little after every edge.
module tb_common_fifo_shift_1w1r_lvl;

  typedef struct {
    int         k;
    int         cnt;
    logic [7:0] dout;
    bit         e, f, af, ae, ov, un;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout_w [3];
  logic       emp_w [3], full_w [3], af_w [3], ae_w [3], ov_w [3], un_w [3];
  logic [2:0] cnt_a, cnt_b;
  logic [0:0] cnt_c;

  int checks = 0;
  int errors = 0;

  exp_t       sb [$];
  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];
  logic [7:0] mq2 [$];
  logic [7:0] mhead [3];

  always #5 clk = ~clk;

  common_fifo_shift_1w1r_lvl #(
    .FIFO_DEPTH(4), .FIFO_WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1),
    .PUSH_ON_FULL_POP(1'b1), .FIFO_RESET_VALUE(8'h00)
  ) u_a (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .wen(wen),
    .dout(dout_w[0]), .ren(ren), .fifo_empty(emp_w[0]), .fifo_full(full_w[0]),
    .fifo_count(cnt_a), .almost_full(af_w[0]), .almost_empty(ae_w[0]),
    .err_overflow(ov_w[0]), .err_underflow(un_w[0])
  );

  common_fifo_shift_1w1r_lvl #(
    .FIFO_DEPTH(4), .FIFO_WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1),
    .PUSH_ON_FULL_POP(1'b0), .FIFO_RESET_VALUE(8'h00)
  ) u_b (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .wen(wen),
    .dout(dout_w[1]), .ren(ren), .fifo_empty(emp_w[1]), .fifo_full(full_w[1]),
    .fifo_count(cnt_b), .almost_full(af_w[1]), .almost_empty(ae_w[1]),
    .err_overflow(ov_w[1]), .err_underflow(un_w[1])
  );

  common_fifo_shift_1w1r_lvl #(
    .FIFO_DEPTH(1), .FIFO_WIDTH(8), .AF_LEVEL(0), .AE_LEVEL(1),
    .PUSH_ON_FULL_POP(1'b1), .FIFO_RESET_VALUE(8'h00)
  ) u_c (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .wen(wen),
    .dout(dout_w[2]), .ren(ren), .fifo_empty(emp_w[2]), .fifo_full(full_w[2]),
    .fifo_count(cnt_c), .almost_full(af_w[2]), .almost_empty(ae_w[2]),
    .err_overflow(ov_w[2]), .err_underflow(un_w[2])
  );

  function automatic int act_cnt(input int k);
    if (k == 0) return int'(cnt_a);
    if (k == 1) return int'(cnt_b);
    return int'(cnt_c);
  endfunction

  task automatic chk(input string name, input int k, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", name, k, $time, act, req);
    end
  endtask

  // Reference: a plain list of accepted words, head at index 0.
  task automatic model_step(input int k, input int depth, input bit pofp,
                            input int af_lvl, inout logic [7:0] q [$]);
    int   sz;
    bit   do_pop, do_push;
    exp_t x;
    sz   = q.size();
    x.k  = k;
    x.ov = 1'b0;
    x.un = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      do_pop  = ren && (sz > 0);
      do_push = wen && ((sz < depth) || (pofp && do_pop));
      x.ov    = wen && !do_push;
      x.un    = ren && (sz == 0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(din);
    end
    if (q.size() > 0) mhead[k] = q[0];
    x.cnt  = q.size();
    x.dout = mhead[k];
    x.e    = (x.cnt == 0);
    x.f    = (x.cnt == depth);
    x.af   = (x.cnt >= af_lvl);
    x.ae   = (x.cnt <= 1);
    sb.push_back(x);
  endtask

  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit f);
    @(negedge clk);
    wen = w; din = d; ren = r; flush = f;
    @(posedge clk);
    model_step(0, 4, 1'b1, 3, mq0);
    model_step(1, 4, 1'b0, 3, mq1);
    model_step(2, 1, 1'b1, 0, mq2);
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_count"}, k, act_cnt(k), 0);
      chk({tag, "_dout"},  k, int'(dout_w[k]), 0);
      chk({tag, "_empty"}, k, int'(emp_w[k]), 1);
      chk({tag, "_full"},  k, int'(full_w[k]), 0);
      chk({tag, "_ae"},    k, int'(ae_w[k]), 1);
      chk({tag, "_af"},    k, int'(af_w[k]), (k == 2) ? 1 : 0);
      chk({tag, "_ovf"},   k, int'(ov_w[k]), 0);
      chk({tag, "_unf"},   k, int'(un_w[k]), 0);
    end
  endtask

  // Pulse reset between edges and look at the outputs before the next edge.
  task automatic async_reset();
    @(negedge clk);
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_state("async_rst");
    #1 reset = 1'b0;
    mq0.delete(); mq1.delete(); mq2.delete();
    for (int k = 0; k < 3; k++) mhead[k] = 8'h00;
  endtask

  // Monitor: compare every prediction made at the last edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        $display("txn inst=%0d cnt=%0d dout=%02h e=%0b f=%0b af=%0b ae=%0b ov=%0b un=%0b",
                 x.k, x.cnt, x.dout, x.e, x.f, x.af, x.ae, x.ov, x.un);
        chk("count", x.k, act_cnt(x.k), x.cnt);
        chk("dout",  x.k, int'(dout_w[x.k]), int'(x.dout));
        chk("empty", x.k, int'(emp_w[x.k]), int'(x.e));
        chk("full",  x.k, int'(full_w[x.k]), int'(x.f));
        chk("almost_full",  x.k, int'(af_w[x.k]), int'(x.af));
        chk("almost_empty", x.k, int'(ae_w[x.k]), int'(x.ae));
        chk("err_overflow", x.k, int'(ov_w[x.k]), int'(x.ov));
        chk("err_underflow", x.k, int'(un_w[x.k]), int'(x.un));
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) mhead[k] = 8'h00;
    #3 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fill and drain.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Push while full with a pop in the same cycle, then drain.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow while full, underflow while empty.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush at count 3 with wen/ren active, then a fresh push.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b1, 1'b1);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset with two entries held.
    cycle(1'b1, 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    async_reset();

    // Simultaneous push/pop at count 1.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end

    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", 0, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
